// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: FSM states and owner encoding shared by the arbiter files
package mem_arb_pkg;
  typedef enum logic [1:0] {CPU, DMA, HOLDOFF} state_t;
  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;
endpackage

// File: rtl/mem_arb_if.sv
// mem_arb_if: CPU, DMA and RAM bus signals seen by the arbiter
interface mem_arb_if;
  logic [15:0] cpu_ab;
  logic [7:0]  cpu_do;
  logic        cpu_we;
  logic        cpu_rdy;
  logic [7:0]  cpu_di;
  logic        dma_req;
  logic [15:0] dma_ab;
  logic        dma_we;
  logic [7:0]  dma_do;
  logic        dma_gnt;
  logic        dma_valid;
  logic [7:0]  dma_di;
  logic [15:0] mem_ab;
  logic        mem_we;
  logic [7:0]  mem_do;
  logic [7:0]  mem_di;
  modport slave (
    input  cpu_ab, cpu_do, cpu_we, dma_req, dma_ab, dma_we, dma_do, mem_di,
    output cpu_rdy, cpu_di, dma_gnt, dma_valid, dma_di, mem_ab, mem_we, mem_do
  );
  modport master (
    output cpu_ab, cpu_do, cpu_we, dma_req, dma_ab, dma_we, dma_do, mem_di,
    input  cpu_rdy, cpu_di, dma_gnt, dma_valid, dma_di, mem_ab, mem_we, mem_do
  );
endinterface

// File: rtl/mem_arb_burst_limiter.sv
// mem_arb_burst_limiter: bounds DMA bursts and enforces guaranteed CPU slots
module mem_arb_burst_limiter
  import mem_arb_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter int CPU_SLOTS = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic grant,
  output logic holdoff
);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int SW = $clog2(CPU_SLOTS + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
  localparam logic [SW-1:0] SLOTS = SW'(CPU_SLOTS);
  state_t state_q, state_d;
  logic [BW-1:0] burst_q, burst_d;
  logic [SW-1:0] slot_q, slot_d;
  logic holdoff_q;
  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    slot_d = slot_q;
    case (state_q)
      CPU, DMA: begin
        burst_d = !grant ? '0 : (state_q == DMA) ? burst_q + 1'b1 : BW'(1);
        state_d = !grant ? CPU : (burst_d == BURST_MAX) ? HOLDOFF : DMA;
        slot_d = (state_d == HOLDOFF) ? SLOTS : slot_q;
      end
      HOLDOFF: begin
        slot_d = slot_q - 1'b1;
        state_d = (slot_q == SW'(1)) ? CPU : HOLDOFF;
        burst_d = (slot_q == SW'(1)) ? '0 : burst_q;
      end
      default: state_d = CPU;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CPU;
      burst_q <= '0;
      slot_q <= '0;
      holdoff_q <= 1'b0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      slot_q <= slot_d;
      holdoff_q <= (state_d == HOLDOFF);
    end
  end
  assign holdoff = holdoff_q;
endmodule

// File: rtl/mem_arb.sv
// mem_arb: shares one RAM between the CPU and a cycle-stealing DMA master
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter int CPU_SLOTS = 1
) (
  input logic clk,
  input logic RST,
  mem_arb_if.slave bus
);
  logic holdoff, grant, own_q, own_d, we_q, we_d;
  mem_arb_burst_limiter #(.MAX_BURST(MAX_BURST), .CPU_SLOTS(CPU_SLOTS)) u_lim (
    .clk(clk),
    .rst(RST),
    .grant(grant),
    .holdoff(holdoff)
  );
  always_comb begin
    grant = ~RST & bus.dma_req & ~bus.cpu_we & ~holdoff;
    own_d = grant ? OWN_DMA : OWN_CPU;
    we_d = grant & bus.dma_we;
  end
  always_ff @(posedge clk) begin
    if (RST) begin
      own_q <= OWN_CPU;
      we_q <= 1'b0;
    end else begin
      own_q <= own_d;
      we_q <= we_d;
    end
  end
  assign bus.mem_ab = grant ? bus.dma_ab : bus.cpu_ab;
  assign bus.mem_we = grant ? bus.dma_we : bus.cpu_we;
  assign bus.mem_do = grant ? bus.dma_do : bus.cpu_do;
  assign bus.dma_gnt = grant;
  assign bus.cpu_rdy = (own_q == OWN_CPU);
  assign bus.dma_valid = (own_q == OWN_DMA) & ~we_q;
  assign bus.cpu_di = bus.mem_di;
  assign bus.dma_di = bus.mem_di;
endmodule
